// File: rtl/lzc_normalizer_pipe.sv
// Two-stage leading/trailing-zero counter and normalizer with a 2-cycle latency and 1 result per cycle.
// Each stage loads only when it advances, so a stalled output holds its result and in_ready follows out_ready.
module lzc_normalizer_pipe #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_zero,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TAG_WIDTH-1:0]   out_tag
);
    localparam int LOG2 = $clog2(DATA_WIDTH);

    function automatic logic [DATA_WIDTH-1:0] bitrev(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = d[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    logic                   s2_adv, s1_adv;
    logic                   s1_valid, s1_zero, s1_mode;
    logic [COUNT_WIDTH-1:0] s1_count;
    logic [DATA_WIDTH-1:0]  s1_data;
    logic [TAG_WIDTH-1:0]   s1_tag;
    logic                   s2_valid, s2_zero;
    logic [COUNT_WIDTH-1:0] s2_count;
    logic [DATA_WIDTH-1:0]  s2_data;
    logic [TAG_WIDTH-1:0]   s2_tag;

    logic [DATA_WIDTH-1:0]  oriented, probe, norm;
    logic [LOG2-1:0]        lz;
    logic                   in_zero;
    logic [COUNT_WIDTH-1:0] in_count;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    // Trailing zeros become leading zeros of the reversed operand; each halving level yields one count bit.
    always_comb begin
        oriented = in_mode ? bitrev(in_data) : in_data;
        probe    = oriented;
        lz       = '0;
        for (int lvl = LOG2 - 1; lvl >= 0; lvl--) begin
            if ((probe & ~({DATA_WIDTH{1'b1}} >> (1 << lvl))) == '0) begin
                lz[lvl] = 1'b1;
                probe   = probe << (1 << lvl);
            end
        end
        in_zero  = (oriented == '0);
        in_count = in_zero ? COUNT_WIDTH'(DATA_WIDTH) : COUNT_WIDTH'(lz);
    end

    // A count of DATA_WIDTH shifts everything out, giving zero data for a zero operand.
    always_comb begin
        norm = s1_mode ? (bitrev(s1_data) >> s1_count) : (s1_data << s1_count);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_count <= '0;
            s1_zero  <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 1'b0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_count <= in_count;
                s1_zero  <= in_zero;
                s1_data  <= oriented;
                s1_mode  <= in_mode;
                s1_tag   <= in_tag;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_count <= '0;
            s2_zero  <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_count <= s1_count;
                s2_zero  <= s1_zero;
                s2_data  <= norm;
                s2_tag   <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_count = s2_count;
    assign out_zero  = s2_zero;
    assign out_data  = s2_data;
    assign out_tag   = s2_tag;
endmodule

// File: tb/tb_lzc_normalizer_pipe.sv
// Bench for lzc_normalizer_pipe: directed 64-bit vectors, stall and reset sequences, and an 8-bit randomized sweep.
module tb_lzc_normalizer_pipe;
    typedef struct packed {
        logic [6:0]  count;
        logic        zero;
        logic [63:0] data;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [3:0]  tag;
        logic [6:0]  cnt;
        logic        zero;
        logic [63:0] odata;
    } vec_t;

    logic clock, reset;

    logic        in_valid64, in_ready64, in_mode64, out_valid64, out_ready64, out_zero64;
    logic [63:0] in_data64, out_data64;
    logic [3:0]  in_tag64, out_tag64;
    logic [6:0]  out_count64;

    logic        in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_zero8;
    logic [7:0]  in_data8, out_data8;
    logic [3:0]  in_tag8, out_tag8;
    logic [3:0]  out_count8;

    exp_t exp64_cur, exp8_cur;
    exp_t q64[$];
    exp_t q8[$];
    int   n_vec, n_err;
    logic done8;
    vec_t tbl[12];

    lzc_normalizer_pipe #(.DATA_WIDTH(64)) dut64 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_mode(in_mode64),
        .in_data(in_data64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_count(out_count64),
        .out_zero(out_zero64), .out_data(out_data64), .out_tag(out_tag64)
    );

    lzc_normalizer_pipe #(.DATA_WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_mode(in_mode8),
        .in_data(in_data8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_count(out_count8),
        .out_zero(out_zero8), .out_data(out_data8), .out_tag(out_tag8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model8(input logic mode, input logic [7:0] d, input logic [3:0] tag);
        exp_t e;
        int c;
        logic [7:0] od;
        c = 8;
        if (mode == 1'b0) begin
            for (int i = 0; i < 8; i++) if (d[i]) c = 7 - i;
        end else begin
            for (int i = 7; i >= 0; i--) if (d[i]) c = i;
        end
        if (c == 8) od = 8'h00;
        else if (mode) od = d >> c;
        else od = d << c;
        e.count = 7'(c);
        e.zero  = (d == 8'h00);
        e.data  = {56'h0, od};
        e.tag   = tag;
        return e;
    endfunction

    // Scoreboard and hold checker for the 64-bit instance.
    initial begin
        exp_t e, h;
        logic hold;
        logic [75:0] act;
        hold = 1'b0;
        h = '0;
        forever begin
            @(negedge clock);
            act = {out_count64, out_zero64, out_data64, out_tag64};
            if (reset) hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold64_valid", 80'(out_valid64), 80'(1));
                    chk("hold64_fields", 80'(act), 80'(h));
                end
                if (out_valid64 && out_ready64) begin
                    if (q64.size() == 0) chk("spurious64", 80'(out_valid64), 80'(0));
                    else begin
                        e = q64.pop_front();
                        chk("result64", 80'(act), 80'(e));
                    end
                end
                hold = out_valid64 && !out_ready64;
                h = act;
                if (in_valid64 && in_ready64) q64.push_back(exp64_cur);
            end
        end
    end

    initial begin
        exp_t e, h;
        logic hold;
        logic [75:0] act;
        hold = 1'b0;
        h = '0;
        forever begin
            @(negedge clock);
            act = {3'b0, out_count8, out_zero8, 56'h0, out_data8, out_tag8};
            if (reset) hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold8_valid", 80'(out_valid8), 80'(1));
                    chk("hold8_fields", 80'(act), 80'(h));
                end
                if (out_valid8 && out_ready8) begin
                    if (q8.size() == 0) chk("spurious8", 80'(out_valid8), 80'(0));
                    else begin
                        e = q8.pop_front();
                        chk("result8", 80'(act), 80'(e));
                    end
                end
                hold = out_valid8 && !out_ready8;
                h = act;
                if (in_valid8 && in_ready8) q8.push_back(exp8_cur);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the operand.
    task automatic send64(input vec_t v);
        int k;
        in_valid64 = 1'b1;
        in_mode64  = v.mode;
        in_data64  = v.data;
        in_tag64   = v.tag;
        exp64_cur  = '{count: v.cnt, zero: v.zero, data: v.odata, tag: v.tag};
        k = 0;
        @(negedge clock);
        while (!in_ready64 && k < 200) begin
            k++;
            @(negedge clock);
        end
        if (!in_ready64) chk("accept64_timeout", 80'(in_ready64), 80'(1));
        @(posedge clock);
        #1;
        in_valid64 = 1'b0;
        in_data64  = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic send64_lat(input vec_t v);
        send64(v);
        @(negedge clock);
        chk("latency_cycle1_valid", 80'(out_valid64), 80'(0));
        @(negedge clock);
        chk("latency_cycle2_valid", 80'(out_valid64), 80'(1));
        @(posedge clock);
        #1;
    endtask

    task automatic send8(input logic mode, input logic [7:0] d, input logic [3:0] tag);
        int k;
        in_valid8 = 1'b1;
        in_mode8  = mode;
        in_data8  = d;
        in_tag8   = tag;
        exp8_cur  = model8(mode, d, tag);
        k = 0;
        @(negedge clock);
        while (!in_ready8 && k < 200) begin
            k++;
            @(negedge clock);
        end
        if (!in_ready8) chk("accept8_timeout", 80'(in_ready8), 80'(1));
        @(posedge clock);
        #1;
        in_valid8 = 1'b0;
        in_data8  = 8'($urandom);
    endtask

    task automatic drain(input bit is8);
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if ((is8 ? q8.size() : q64.size()) == 0) break;
        end
        chk(is8 ? "drain8_pending" : "drain64_pending", 80'(is8 ? q8.size() : q64.size()), 80'(0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t v;
        int c;
        n_vec = 0;
        n_err = 0;
        done8 = 1'b0;
        reset = 1'b0;
        in_valid64 = 1'b0; in_mode64 = 1'b0; in_data64 = '0; in_tag64 = '0; out_ready64 = 1'b1;
        in_valid8  = 1'b0; in_mode8  = 1'b0; in_data8  = '0; in_tag8  = '0; out_ready8  = 1'b1;
        exp64_cur = '0;
        exp8_cur  = '0;

        tbl[0]  = '{1'b0, 64'h0000_0000_0000_1000, 4'd3,  7'd51, 1'b0, 64'h8000_0000_0000_0000};
        tbl[1]  = '{1'b1, 64'h0000_0000_0000_0A00, 4'd1,  7'd9,  1'b0, 64'h0000_0000_0000_0005};
        tbl[2]  = '{1'b0, 64'h0,                   4'd2,  7'd64, 1'b1, 64'h0};
        tbl[3]  = '{1'b1, 64'h0,                   4'd4,  7'd64, 1'b1, 64'h0};
        tbl[4]  = '{1'b0, 64'h8000_0000_0000_0000, 4'd5,  7'd0,  1'b0, 64'h8000_0000_0000_0000};
        tbl[5]  = '{1'b1, 64'h8000_0000_0000_0000, 4'd6,  7'd63, 1'b0, 64'h0000_0000_0000_0001};
        tbl[6]  = '{1'b0, 64'h0000_0000_0000_0001, 4'd7,  7'd63, 1'b0, 64'h8000_0000_0000_0000};
        tbl[7]  = '{1'b1, 64'h0000_0000_0000_0001, 4'd8,  7'd0,  1'b0, 64'h0000_0000_0000_0001};
        tbl[8]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd9,  7'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[9]  = '{1'b1, 64'h0000_0001_0000_0000, 4'd10, 7'd32, 1'b0, 64'h0000_0000_0000_0001};
        tbl[10] = '{1'b0, 64'h0000_0000_F000_0000, 4'd11, 7'd32, 1'b0, 64'hF000_0000_0000_0000};
        tbl[11] = '{1'b1, 64'h0300_0000_0000_0000, 4'd12, 7'd56, 1'b0, 64'h0000_0000_0000_0003};

        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_out_valid", 80'(out_valid64), 80'(0));
        chk("reset_out_fields", 80'({out_count64, out_zero64, out_data64, out_tag64}), 80'(0));
        chk("reset_out_valid8", 80'(out_valid8), 80'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        send64_lat(tbl[0]);
        for (int i = 1; i < 12; i++) send64(tbl[i]);
        drain(1'b0);

        // Six back-to-back operands with a 4-cycle output stall.
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    v.mode  = k[0];
                    v.data  = 64'h1 << (10 * k);
                    v.tag   = 4'(k);
                    v.cnt   = k[0] ? 7'(10 * k) : 7'(63 - 10 * k);
                    v.zero  = 1'b0;
                    v.odata = k[0] ? 64'h1 : 64'h8000_0000_0000_0000;
                    send64(v);
                end
            end
            begin
                @(posedge clock);
                @(posedge clock);
                #1 out_ready64 = 1'b0;
                repeat (4) begin
                    @(negedge clock);
                    chk("stall_in_ready", 80'(in_ready64), 80'(0));
                end
                @(posedge clock);
                #1 out_ready64 = 1'b1;
                c = 0;
                repeat (6) begin
                    @(negedge clock);
                    if (out_valid64) c++;
                end
                chk("release_rate", 80'(c), 80'(6));
            end
        join
        drain(1'b0);

        // Asynchronous reset with two operands in flight.
        send64('{1'b0, 64'h0000_0000_0000_1000, 4'd13, 7'd51, 1'b0, 64'h8000_0000_0000_0000});
        send64('{1'b1, 64'h0000_0000_0000_0A00, 4'd14, 7'd9, 1'b0, 64'h5});
        chk("pre_reset_valid", 80'(out_valid64), 80'(1));
        #2 reset = 1'b1;
        q64.delete();
        q8.delete();
        #1;
        chk("async_reset_valid", 80'(out_valid64), 80'(0));
        chk("async_reset_fields", 80'({out_count64, out_zero64, out_data64, out_tag64}), 80'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        send64_lat(tbl[5]);
        drain(1'b0);

        // 8-bit: exhaustive operands in both modes, then random traffic.
        fork
            begin
                while (!done8) begin
                    @(posedge clock);
                    #1 out_ready8 = ($urandom_range(3) != 0);
                end
            end
            begin
                for (int n = 0; n < 10000; n++) begin
                    while ($urandom_range(3) == 0) begin
                        in_valid8 = 1'b0;
                        in_data8  = 8'($urandom);
                        @(posedge clock);
                        #1;
                    end
                    if (n < 512) send8(n[8], n[7:0], n[3:0]);
                    else send8(1'($urandom), 8'($urandom), n[3:0]);
                end
                done8 = 1'b1;
            end
        join
        out_ready8 = 1'b1;
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
